// File: rtl/me_mb_scheduler.sv
// Frame-level macroblock sequencer for the hexagon motion-estimation engine.
// Walks every 16x16 macroblock in raster order, drives the engine, collects
// mv_x/mv_y/sad into one ready/valid record per macroblock and keeps a
// frame-total SAD. Supports abort with a clean engine handshake unwind.
module me_mb_scheduler #(
    parameter int WIDTH  = 352,
    parameter int HEIGHT = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        abort,
    input  logic [31:0] cur_base,
    input  logic [31:0] ref_base,
    output logic        me_start,
    output logic [31:0] me_frame_addr,
    output logic [31:0] me_ref_addr,
    output logic [31:0] me_mb_x,
    output logic [31:0] me_mb_y,
    input  logic [5:0]  me_mv_x,
    input  logic [5:0]  me_mv_y,
    input  logic [15:0] me_sad,
    input  logic        me_done,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [8:0]  res_mb_idx,
    output logic [5:0]  res_mv_x,
    output logic [5:0]  res_mv_y,
    output logic [15:0] res_sad,
    output logic [24:0] total_sad,
    output logic        busy,
    output logic        frame_done
);

    localparam int          MB_COLS  = WIDTH / 16;
    localparam int          MB_ROWS  = HEIGHT / 16;
    localparam logic [8:0]  IDX_LAST = 9'(MB_COLS * MB_ROWS - 1);
    localparam logic [31:0] X_LAST   = 32'(WIDTH - 16);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        PUSH,
        WAIT_REL,
        FIN,
        ABORT_HI,
        ABORT_LO
    } state_t;

    state_t      state, state_d;
    logic [8:0]  mb_idx, mb_idx_d;
    logic        me_start_d;
    logic [31:0] me_frame_addr_d, me_ref_addr_d, me_mb_x_d, me_mb_y_d;
    logic        res_valid_d;
    logic [8:0]  res_mb_idx_d;
    logic [5:0]  res_mv_x_d, res_mv_y_d;
    logic [15:0] res_sad_d;
    logic [24:0] total_sad_d;
    logic        busy_d, frame_done_d;

    // Register state and every output so nothing downstream sees a combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mb_idx        <= '0;
            me_start      <= 1'b0;
            me_frame_addr <= '0;
            me_ref_addr   <= '0;
            me_mb_x       <= '0;
            me_mb_y       <= '0;
            res_valid     <= 1'b0;
            res_mb_idx    <= '0;
            res_mv_x      <= '0;
            res_mv_y      <= '0;
            res_sad       <= '0;
            total_sad     <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_d;
            mb_idx        <= mb_idx_d;
            me_start      <= me_start_d;
            me_frame_addr <= me_frame_addr_d;
            me_ref_addr   <= me_ref_addr_d;
            me_mb_x       <= me_mb_x_d;
            me_mb_y       <= me_mb_y_d;
            res_valid     <= res_valid_d;
            res_mb_idx    <= res_mb_idx_d;
            res_mv_x      <= res_mv_x_d;
            res_mv_y      <= res_mv_y_d;
            res_sad       <= res_sad_d;
            total_sad     <= total_sad_d;
            busy          <= busy_d;
            frame_done    <= frame_done_d;
        end
    end

    // Next-state and next-output logic; abort is checked first in each busy state.
    always_comb begin
        state_d         = state;
        mb_idx_d        = mb_idx;
        me_start_d      = me_start;
        me_frame_addr_d = me_frame_addr;
        me_ref_addr_d   = me_ref_addr;
        me_mb_x_d       = me_mb_x;
        me_mb_y_d       = me_mb_y;
        res_valid_d     = res_valid;
        res_mb_idx_d    = res_mb_idx;
        res_mv_x_d      = res_mv_x;
        res_mv_y_d      = res_mv_y;
        res_sad_d       = res_sad;
        total_sad_d     = total_sad;
        frame_done_d    = 1'b0;

        case (state)
            IDLE: begin
                if (frame_start) begin
                    me_frame_addr_d = cur_base;
                    me_ref_addr_d   = ref_base;
                    me_mb_x_d       = '0;
                    me_mb_y_d       = '0;
                    mb_idx_d        = '0;
                    total_sad_d     = '0;
                    me_start_d      = 1'b1;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    me_start_d = 1'b0;
                    state_d    = me_done ? ABORT_LO : ABORT_HI;
                end else if (me_done) begin
                    res_mv_x_d   = me_mv_x;
                    res_mv_y_d   = me_mv_y;
                    res_sad_d    = me_sad;
                    res_mb_idx_d = mb_idx;
                    total_sad_d  = total_sad + 25'(me_sad);
                    me_start_d   = 1'b0;
                    res_valid_d  = 1'b1;
                    state_d      = PUSH;
                end
            end
            PUSH: begin
                if (abort) begin
                    res_valid_d = 1'b0;
                    state_d     = ABORT_LO;
                end else if (res_valid && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (abort) begin
                    state_d = ABORT_LO;
                end else if (!me_done) begin
                    if (mb_idx == IDX_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = FIN;
                    end else begin
                        if (me_mb_x == X_LAST) begin
                            me_mb_x_d = '0;
                            me_mb_y_d = me_mb_y + 32'd16;
                        end else begin
                            me_mb_x_d = me_mb_x + 32'd16;
                        end
                        mb_idx_d   = mb_idx + 9'd1;
                        me_start_d = 1'b1;
                        state_d    = ISSUE;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            ABORT_HI: begin
                if (me_done) state_d = ABORT_LO;
            end
            ABORT_LO: begin
                if (!me_done) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_me_mb_scheduler.sv
// Directed self-checking bench for me_mb_scheduler with a fixed-latency
// engine model that holds done for two cycles after start falls.
module tb_me_mb_scheduler;

    localparam int LAT  = 4;
    localparam int COLS = 22;
    localparam int NMB  = 330;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cur_base = '0;
    logic [31:0] ref_base = '0;
    logic        me_start;
    logic [31:0] me_frame_addr, me_ref_addr, me_mb_x, me_mb_y;
    logic [5:0]  me_mv_x, me_mv_y;
    logic [15:0] me_sad;
    logic        me_done;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [8:0]  res_mb_idx;
    logic [5:0]  res_mv_x, res_mv_y;
    logic [15:0] res_sad;
    logic [24:0] total_sad;
    logic        busy, frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_fdone  = 0;

    me_mb_scheduler #(.WIDTH(352), .HEIGHT(240)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
        .cur_base(cur_base), .ref_base(ref_base), .me_start(me_start),
        .me_frame_addr(me_frame_addr), .me_ref_addr(me_ref_addr),
        .me_mb_x(me_mb_x), .me_mb_y(me_mb_y), .me_mv_x(me_mv_x),
        .me_mv_y(me_mv_y), .me_sad(me_sad), .me_done(me_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_mb_idx(res_mb_idx),
        .res_mv_x(res_mv_x), .res_mv_y(res_mv_y), .res_sad(res_sad),
        .total_sad(total_sad), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sad_of(input int i);
        return 16'((i * 197 + 1000) & 32'hFFFF);
    endfunction
    function automatic logic [5:0] mvx_of(input int i);
        return 6'((i * 3 + 44) & 32'h3F);
    endfunction
    function automatic logic [5:0] mvy_of(input int i);
        return 6'((i ^ 42) & 32'h3F);
    endfunction

    // Engine model: finishes a job LAT cycles after start, holds done two cycles after start drops.
    int m_cnt;
    bit m_run, m_hold;
    int m_idx;
    assign m_idx = int'(me_mb_y / 16) * COLS + int'(me_mb_x / 16);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_run <= 1'b0; m_hold <= 1'b0;
            me_done <= 1'b0; me_mv_x <= '0; me_mv_y <= '0; me_sad <= '0;
        end else if (me_done) begin
            if (!me_start) begin
                if (m_hold) begin me_done <= 1'b0; m_hold <= 1'b0; end
                else m_hold <= 1'b1;
            end
        end else if (m_run || me_start) begin
            if (m_cnt == LAT - 1) begin
                me_done <= 1'b1; m_run <= 1'b0; m_cnt <= 0;
                me_sad <= sad_of(m_idx); me_mv_x <= mvx_of(m_idx); me_mv_y <= mvy_of(m_idx);
            end else begin
                m_cnt <= m_cnt + 1; m_run <= 1'b1;
            end
        end
    end

    // Count accepted records and frame_done pulses.
    always @(posedge clk) begin
        if (res_valid && res_ready) n_acc <= n_acc + 1;
        if (frame_done) n_fdone <= n_fdone + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok, output bit saw_hi);
        ok = 1'b0; saw_hi = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (me_done) saw_hi = 1'b1;
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_fs(input logic [31:0] cb, input logic [31:0] rb);
        @(negedge clk);
        cur_base = cb; ref_base = rb; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, me_start, 0);
        check({tag, "_faddr"}, me_frame_addr, 0);
        check({tag, "_raddr"}, me_ref_addr, 0);
        check({tag, "_pos"}, {me_mb_x, me_mb_y}, 0);
        check({tag, "_valid"}, res_valid, 0);
        check({tag, "_res"}, {res_mb_idx, res_mv_x, res_mv_y, res_sad}, 0);
        check({tag, "_total"}, total_sad, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fdone"}, frame_done, 0);
    endtask

    initial begin
        bit ok, saw_hi;
        int cnt, acc0, fd0;
        logic [24:0] exp_total;
        logic [36:0] snap;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Full frame with backpressure on record 5
        exp_total = '0;
        for (int i = 0; i < NMB; i++) exp_total += 25'(sad_of(i));
        pulse_fs(32'h1000_0000, 32'h2000_0000);
        check("fs_start", me_start, 1);
        check("fs_busy", busy, 1);
        check("fs_faddr", me_frame_addr, 32'h1000_0000);
        check("fs_raddr", me_ref_addr, 32'h2000_0000);
        for (int n = 0; n < NMB; n++) begin
            res_ready = (n != 5);
            wait_valid(ok);
            check("rec_timeout", ok, 1);
            if (!ok) break;
            check("rec_idx", res_mb_idx, n);
            check("rec_x", me_mb_x, (n % COLS) * 16);
            check("rec_y", me_mb_y, (n / COLS) * 16);
            check("rec_sad", res_sad, sad_of(n));
            check("rec_mv", {res_mv_x, res_mv_y}, {mvx_of(n), mvy_of(n)});
            check("rec_start_low", me_start, 0);
            if (n == 5) begin
                snap = {res_sad, res_mv_x, res_mv_y, res_mb_idx};
                repeat (10) begin
                    @(negedge clk);
                    check("bp_valid", res_valid, 1);
                    check("bp_hold", {res_sad, res_mv_x, res_mv_y, res_mb_idx}, snap);
                    check("bp_start", me_start, 0);
                end
                res_ready = 1'b1;
            end else if (n != NMB - 1) begin
                cnt = 0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    cnt++;
                    if (me_start) break;
                end
                check("overhead", cnt, 3);
            end
        end
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (frame_done) begin ok = 1'b1; break; end
        end
        check("fdone_seen", ok, 1);
        repeat (3) @(negedge clk);
        check("fdone_count", n_fdone, 1);
        check("total_sad", total_sad, exp_total);
        check("rec_count", n_acc, NMB);
        check("end_busy", busy, 0);

        // Abort in ISSUE while done is low
        pulse_fs(32'h3000_0000, 32'h4000_0000);
        acc0 = n_acc; fd0 = n_fdone;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab1_start", me_start, 0);
        check("ab1_busy", busy, 1);
        check("ab1_done_low", me_done, 0);
        wait_idle(ok, saw_hi);
        check("ab1_idle", ok, 1);
        check("ab1_done_cycle", saw_hi, 1);
        check("ab1_done_after", me_done, 0);
        check("ab1_norec", n_acc, acc0);
        check("ab1_nofdone", n_fdone, fd0);

        // Abort coincident with done
        pulse_fs(32'h5000_0000, 32'h6000_0000);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (me_done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("ab2_done_seen", ok, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab2_valid", res_valid, 0);
        check("ab2_start", me_start, 0);
        check("ab2_total", total_sad, 0);
        check("ab2_busy", busy, 1);
        wait_idle(ok, saw_hi);
        check("ab2_idle", ok, 1);
        check("ab2_norec", n_acc, acc0);
        check("ab2_nofdone", n_fdone, fd0);

        // Restart at idx 0, ignored frame_start while busy, reset mid-PUSH
        res_ready = 1'b0;
        pulse_fs(32'h7000_0000, 32'h8000_0000);
        wait_valid(ok);
        check("rs_timeout", ok, 1);
        check("rs_idx", res_mb_idx, 0);
        check("rs_pos", {me_mb_x, me_mb_y}, 0);
        check("rs_total", total_sad, sad_of(0));
        check("rs_sad", res_sad, sad_of(0));
        pulse_fs(32'h9000_0000, 32'hA000_0000);
        check("ign_faddr", me_frame_addr, 32'h7000_0000);
        check("ign_raddr", me_ref_addr, 32'h8000_0000);
        check("ign_pos", {me_mb_x, me_mb_y}, 0);
        check("ign_valid", res_valid, 1);
        check("ign_idx", res_mb_idx, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_start", me_start, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/me_mb_scheduler.md
# me_mb_scheduler

Frame-level macroblock sequencer that sits directly upstream of the hexagon-based motion-estimation engine. On a frame start it walks every 16x16 macroblock of the current frame in raster order. For each one it drives the engine's start/position/base-address inputs, waits for the engine's done, and captures mv_x/mv_y/sad. It then pushes one result record per macroblock to a downstream ready/valid consumer and keeps a frame-total SAD.

## Interface
- WIDTH, 352, frame width in pixels; multiple of 16
- HEIGHT, 240, frame height in pixels; multiple of 16
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  single-cycle request to process one frame; ignored unless IDLE
- abort  in  1  single-cycle request to stop the current frame
- cur_base  in  32  current-frame base address, sampled on frame_start
- ref_base  in  32  reference-frame base address, sampled on frame_start
- me_start  out  1  engine start, level
- me_frame_addr  out  32  to engine frame_start_addr
- me_ref_addr  out  32  to engine ref_start_addr
- me_mb_x  out  32  to engine mb_x_pos (pixels)
- me_mb_y  out  32  to engine mb_y_pos (pixels)
- me_mv_x  in  6  engine mv_x, signed
- me_mv_y  in  6  engine mv_y, signed
- me_sad  in  16  engine sad
- me_done  in  1  engine done, level
- res_valid  out  1  result record valid
- res_ready  in  1  consumer ready
- res_mb_idx  out  9  raster macroblock index, 0..(WIDTH/16)*(HEIGHT/16)-1
- res_mv_x  out  6  signed
- res_mv_y  out  6  signed
- res_sad  out  16  result SAD
- total_sad  out  25  sum of res_sad over the frame, exact with no saturation (330*65535 < 2^25)
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last record is accepted

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE.
- States: IDLE, ISSUE, PUSH, WAIT_REL, FIN, ABORT_HI, ABORT_LO.
- **IDLE**
  - On frame_start, latch cur_base/ref_base into me_frame_addr/me_ref_addr.
  - Set me_mb_x=0, me_mb_y=0, mb_idx=0, total_sad=0, me_start=1, then go to ISSUE.
- **ISSUE**
  - Hold me_start=1 and all position/address outputs stable.
  - On me_done=1: latch me_mv_x/me_mv_y/me_sad into res_*, set res_mb_idx=mb_idx, add me_sad to total_sad, set me_start=0 and res_valid=1, then go to PUSH.
- **PUSH**
  - Hold res_* stable while res_valid=1.
  - On res_valid and res_ready: res_valid=0, go to WAIT_REL.
- **WAIT_REL**
  - Wait for me_done=0. This is required because the engine holds done high for two cycles after start falls.
  - If mb_idx is the last macroblock, go to FIN.
  - Otherwise advance: me_mb_x += 16; if the old me_mb_x was WIDTH-16, set me_mb_x=0 and me_mb_y += 16. Increment mb_idx, set me_start=1, go to ISSUE.
- **FIN**: frame_done=1 for one cycle, then IDLE. total_sad holds until the next accepted frame_start.
- **Abort** (ignored in IDLE and FIN; takes priority over every other event in the same cycle):
  - From ISSUE, including the cycle where me_done=1: me_start=0, discard any result, no total_sad update. Go to ABORT_HI if me_done=0, else ABORT_LO.
  - From PUSH: res_valid=0. This is the only case in which valid is withdrawn without acceptance. Go to ABORT_LO.
  - From WAIT_REL: go to ABORT_LO.
  - ABORT_HI waits for me_done=1, then goes to ABORT_LO. ABORT_LO waits for me_done=0, then goes to IDLE.
  - No frame_done pulse on abort.
- Reset mid-frame returns to IDLE immediately. The engine is reset by the same rst_n.

## Timing
- frame_start sampled at edge n -> me_start=1 from edge n.
- me_done sampled high at edge e -> me_start=0 and res_valid=1 from edge e.
- With res_ready held 1:
  - record accepted at edge e+1;
  - WAIT_REL samples me_done=0 at edge e+3;
  - next me_start=1 from edge e+3.
- Each macroblock therefore has 3 cycles of scheduler overhead beyond engine latency. Each extra cycle of res_ready=0 adds one cycle.
- me_mb_x/me_mb_y/me_*_addr change only on the edge that enters ISSUE.

## Test plan
- **Full frame**, WIDTH=352, HEIGHT=240, engine model with fixed latency, res_ready=1 -> 330 records, idx 0..329 in raster order. Record 22 has me_mb_x=0, me_mb_y=16. Last record has x=336, y=224. frame_done pulses once. total_sad equals the sum of model SADs.
- **Overhead check** with res_ready=1 -> me_start re-rises exactly 3 cycles after each done-high sample edge.
- **Backpressure**: res_ready=0 for 10 cycles on record 5 -> res_* stable and res_valid high throughout. me_start stays 0 until acceptance. No record is lost or duplicated.
- **Abort in ISSUE** with me_done=0 -> me_start falls, no record. Scheduler returns to IDLE only after the model's done rises and falls. frame_done stays 0.
- **Abort coincident with me_done=1** -> no record, total_sad unchanged, ABORT_LO, then IDLE once done=0. A following frame_start restarts at idx 0.
- **frame_start while busy** is ignored, with no position change. Reset asserted mid-PUSH -> all outputs 0 and state IDLE.
